i2c_bit_ctrl: RTL

Bit-level I2C engine sitting directly below the byte controller and directly above the pads. It executes one bus primitive at a time (START, STOP, WRITE bit, READ bit) from the `I2C_CMD_*` encodings, driving SCL/SDA open-drain through the `i2c_if` dut modport. It also handles clock stretching, arbitration loss and bus-busy detection. Bit timing comes from the PSCR prescaler value.

---
 rtl/i2c_bit_ctrl_pkg.sv | 97 +++++++++
 rtl/i2c_if.sv | 26 ++
 rtl/i2c_sync2.sv | 29 ++
 rtl/i2c_bit_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_bit_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bit_ctrl_pkg
// Description : Shared I2C definitions: command encodings, prescaler limits,
//               bit-engine state type and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_bit_ctrl_pkg;

    localparam int I2C_PSCR_WIDTH   = 16;
    localparam int I2C_PSCR_MIN_VAL = 2;

    localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
    localparam logic [3:0] I2C_CMD_START = 4'b0001;
    localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
    localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
    localparam logic [3:0] I2C_CMD_READ  = 4'b1000;

    typedef enum logic [4:0] {
        IDLE,
        START_A, START_B, START_C, START_D, START_E,
        STOP_A,  STOP_B,  STOP_C,  STOP_D,
        WR_A,    WR_B,    WR_C,    WR_D,
        RD_A,    RD_B,    RD_C,    RD_D
    } i2c_bit_state_e;

    // True when exactly one command bit is set.
    function automatic logic is_onehot4(input logic [3:0] cmd);
        return (cmd != 4'b0000) && ((cmd & (cmd - 4'd1)) == 4'b0000);
    endfunction

    // First phase of a (one-hot) command.
    function automatic i2c_bit_state_e first_phase(input logic [3:0] cmd);
        i2c_bit_state_e s;
        case (cmd)
            I2C_CMD_START: s = START_A;
            I2C_CMD_STOP:  s = STOP_A;
            I2C_CMD_WRITE: s = WR_A;
            I2C_CMD_READ:  s = RD_A;
            default:       s = IDLE;
        endcase
        return s;
    endfunction

    // Phase sequencing; the last phase of every primitive returns to IDLE.
    function automatic i2c_bit_state_e next_phase(input i2c_bit_state_e cur);
        i2c_bit_state_e s;
        case (cur)
            START_A: s = START_B;
            START_B: s = START_C;
            START_C: s = START_D;
            START_D: s = START_E;
            STOP_A:  s = STOP_B;
            STOP_B:  s = STOP_C;
            STOP_C:  s = STOP_D;
            WR_A:    s = WR_B;
            WR_B:    s = WR_C;
            WR_C:    s = WR_D;
            RD_A:    s = RD_B;
            RD_B:    s = RD_C;
            RD_C:    s = RD_D;
            default: s = IDLE;
        endcase
        return s;
    endfunction

    // Pad direction for a phase as {scl_dir, sda_dir}; 1 pulls the line low.
    // scl_hold keeps SCL where it is for START_A (idle bus vs repeated START).
    function automatic logic [1:0] phase_lines(input i2c_bit_state_e s,
                                               input logic scl_hold,
                                               input logic d);
        logic [1:0] l;
        case (s)
            START_A: l = {scl_hold, 1'b0};
            START_B: l = 2'b00;
            START_C: l = 2'b01;
            START_D: l = 2'b01;
            START_E: l = 2'b11;
            STOP_A:  l = 2'b11;
            STOP_B:  l = 2'b01;
            STOP_C:  l = 2'b01;
            STOP_D:  l = 2'b00;
            WR_A:    l = {1'b1, ~d};
            WR_B:    l = {1'b0, ~d};
            WR_C:    l = {1'b0, ~d};
            WR_D:    l = {1'b1, ~d};
            RD_A:    l = 2'b10;
            RD_B:    l = 2'b00;
            RD_C:    l = 2'b00;
            RD_D:    l = 2'b10;
            default: l = 2'b00;
        endcase
        return l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_if
// Description : Open-drain I2C pad bundle (SCL/SDA in, out, direction, irq).
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_if;
    logic scl_i;
    logic sda_i;
    logic scl_o;
    logic sda_o;
    logic scl_dir_o;
    logic sda_dir_o;
    logic irq_o;

    modport dut (
        input  scl_i,
        input  sda_i,
        output scl_o,
        output sda_o,
        output scl_dir_o,
        output sda_dir_o,
        output irq_o
    );
endinterface
`default_nettype wire

// File: rtl/i2c_sync2.sv
`default_nettype none
// ============================================================================
// Module      : i2c_sync2
// Description : Two-flop synchronizer; resets to 1, the idle bus level.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    // Double-register the asynchronous pad input.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule
`default_nettype wire

// File: rtl/i2c_bit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bit_ctrl
// Description : I2C bit engine: executes START/STOP/WRITE/READ primitives on
//               open-drain SCL/SDA with clock stretching, arbitration-loss
//               and bus-busy detection.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bit_ctrl
    import i2c_bit_ctrl_pkg::*;
#(
    parameter int PSCR_W = I2C_PSCR_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [PSCR_W-1:0] pscr_i,
    input  logic              cmd_valid_i,
    input  logic [3:0]        cmd_i,
    input  logic              din_i,
    output logic              cmd_ack_o,
    output logic              dout_o,
    output logic              busy_o,
    output logic              al_o,
    i2c_if.dut                i2c
);

    // ------------------------------------------------------------------
    // Synchronized pads and bus event detection
    // ------------------------------------------------------------------
    logic w_scl_s;
    logic w_sda_s;
    logic r_sda_d;
    logic r_busy;
    logic w_bus_start;
    logic w_bus_stop;

    i2c_sync2 u_scl_sync (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (i2c.scl_i),
        .o_q   (w_scl_s)
    );

    i2c_sync2 u_sda_sync (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (i2c.sda_i),
        .o_q   (w_sda_s)
    );

    assign w_bus_start = r_sda_d & ~w_sda_s & w_scl_s;
    assign w_bus_stop  = ~r_sda_d & w_sda_s & w_scl_s;

    // Track SDA history and bus ownership; runs regardless of en_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sda_d <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_sda_d <= w_sda_s;
            if (w_bus_start) begin
                r_busy <= 1'b1;
            end else if (w_bus_stop) begin
                r_busy <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Phase engine
    // ------------------------------------------------------------------
    i2c_bit_state_e    r_state;
    i2c_bit_state_e    w_state_nxt;
    logic [PSCR_W-1:0] r_cnt;
    logic [PSCR_W-1:0] w_cnt_nxt;
    logic [PSCR_W-1:0] w_pscr_eff;
    logic [3:0]        r_cmd;
    logic [3:0]        w_cmd_nxt;
    logic              r_din;
    logic              w_din_nxt;
    logic              r_dout;
    logic              w_dout_nxt;
    logic              r_ack;
    logic              w_ack_nxt;
    logic              r_al;
    logic              w_al_nxt;
    logic              r_scl_dir;
    logic              w_scl_dir_nxt;
    logic              r_sda_dir;
    logic              w_sda_dir_nxt;
    logic              w_line_din;
    logic              w_stretch;
    logic              w_phase_done;
    logic              w_pin_al;
    logic              w_stop_al;
    logic              w_al_det;

    assign w_pscr_eff = (pscr_i < PSCR_W'(I2C_PSCR_MIN_VAL)) ?
                        PSCR_W'(I2C_PSCR_MIN_VAL) : pscr_i;

    // SCL released by us but still seen low: a slave (or sync delay) is
    // stretching the clock, so the phase timer must wait.
    assign w_stretch    = ~r_scl_dir & ~w_scl_s;
    assign w_phase_done = (r_cnt == '0) & ~w_stretch;

    // Another master pulled SDA low while we released it with SCL high.
    assign w_pin_al  = ~r_sda_dir & w_scl_s & ~w_sda_s &
                       ((r_state == WR_B) | (r_state == WR_C) | (r_state == START_B));
    // A STOP on the bus that we did not generate.
    assign w_stop_al = w_bus_stop & (r_state != IDLE) & (r_cmd != I2C_CMD_STOP);
    assign w_al_det  = w_pin_al | w_stop_al;

    // Next-state, phase timer and registered-output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cmd_nxt     = r_cmd;
        w_din_nxt     = r_din;
        w_dout_nxt    = r_dout;
        w_ack_nxt     = 1'b0;
        w_al_nxt      = 1'b0;
        w_scl_dir_nxt = r_scl_dir;
        w_sda_dir_nxt = r_sda_dir;
        w_line_din    = r_din;

        if (!en_i) begin
            w_state_nxt   = IDLE;
            w_cnt_nxt     = '0;
            w_scl_dir_nxt = 1'b0;
            w_sda_dir_nxt = 1'b0;
        end else if (w_al_det) begin
            w_state_nxt   = IDLE;
            w_cnt_nxt     = '0;
            w_scl_dir_nxt = 1'b0;
            w_sda_dir_nxt = 1'b0;
            w_al_nxt      = 1'b1;
        end else if (r_state == IDLE) begin
            if (cmd_valid_i && is_onehot4(cmd_i)) begin
                w_state_nxt = first_phase(cmd_i);
                w_cmd_nxt   = cmd_i;
                w_din_nxt   = din_i;
                w_line_din  = din_i;
            end
        end else begin
            if (!w_stretch && (r_cnt != '0)) begin
                w_cnt_nxt = r_cnt - PSCR_W'(1);
            end
            if (w_phase_done) begin
                if (r_state == RD_C) begin
                    w_dout_nxt = w_sda_s;
                end
                w_state_nxt = next_phase(r_state);
                if (w_state_nxt == IDLE) begin
                    w_ack_nxt = 1'b1;
                    w_cnt_nxt = '0;
                end
            end
        end

        // Entering a new phase: reload the timer and set the pad levels so
        // they change on the first cycle of the phase.
        if ((w_state_nxt != r_state) && (w_state_nxt != IDLE)) begin
            w_cnt_nxt = w_pscr_eff;
            {w_scl_dir_nxt, w_sda_dir_nxt} = phase_lines(w_state_nxt, r_scl_dir, w_line_din);
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_cmd     <= I2C_CMD_NOP;
            r_din     <= 1'b0;
            r_dout    <= 1'b0;
            r_ack     <= 1'b0;
            r_al      <= 1'b0;
            r_scl_dir <= 1'b0;
            r_sda_dir <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cmd     <= w_cmd_nxt;
            r_din     <= w_din_nxt;
            r_dout    <= w_dout_nxt;
            r_ack     <= w_ack_nxt;
            r_al      <= w_al_nxt;
            r_scl_dir <= w_scl_dir_nxt;
            r_sda_dir <= w_sda_dir_nxt;
        end
    end

    assign cmd_ack_o     = r_ack;
    assign dout_o        = r_dout;
    assign busy_o        = r_busy;
    assign al_o          = r_al;
    assign i2c.scl_o     = 1'b0;
    assign i2c.sda_o     = 1'b0;
    assign i2c.scl_dir_o = r_scl_dir;
    assign i2c.sda_dir_o = r_sda_dir;
    assign i2c.irq_o     = 1'b0;

endmodule
`default_nettype wire
